io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised memory-mapped I/O bank for the single-cycle CPU: NUM_IN debounced switch input ports and NUM_OUT writable output ports, each output driving a two-digit active-low 7-segment pair. Sits between the CPU data-memory I/O decode and the board pins, and replaces the fixed two-input/three-output switch/segment wiring. Adds switch debouncing, sticky change flags, out-of-range display and sequential decimal conversion.

## Interface

- NUM_IN, 2: number of input ports, 1..8
- SW_PER_IN, 5: switches per input port, 1..16
- NUM_OUT, 3: number of output ports, 1..8
- DEBOUNCE_CYCLES, 16: consecutive stable cycles before a switch change is accepted, ≥2
- LZ_BLANK, 0: 1 blanks the tens digit when it is 0

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- sw  in  NUM_IN*SW_PER_IN  raw switches; port i uses bits [i*SW_PER_IN +: SW_PER_IN]
- io_addr  in  8  byte offset into the I/O region
- io_we  in  1  write strobe, sampled on clk
- io_wdata  in  32  write data
- io_rdata  out  32  read data, combinational from io_addr and registered state
- hex_out  out  14*NUM_OUT  port j at [14j +: 14]; [14j+13:14j+7] tens, [14j+6:14j] ones; active-low, bit 6 = segment g

## Operation

- Address map (word-aligned; io_addr[1:0] ignored):
  - 0x00+4i: input port i, read-only, zero-extended debounced switches.
  - 0x40+4j: output port j, read/write, full 32-bit register.
  - 0x7C: status, read; bits [NUM_IN-1:0] are sticky change flags; write is W1C.
  - Any other address: read 0; write ignored.
- Input path, per switch: 2-FF synchroniser, then a counter of cycles where the synchronised value ≠ the debounced value. The counter clears when they are equal. When it reaches DEBOUNCE_CYCLES-1 while still unequal, the debounced bit takes the synchronised value on that edge and the counter clears.
- Change flag i sets on any edge where a debounced bit of port i changes.
  - W1C write and a set in the same cycle: the set wins.
- Output path, per port:
  - A write loads the 32-bit register and starts conversion (CONV) of the new value.
  - FSM states:
    - IDLE.
    - CONV: 7 double-dabble shift steps on value[6:0], step counter 0..6.
    - LOAD: hex pair updated, then back to IDLE.
  - Value > 99 (unsigned, full 32 bits): LOAD shows dashes, 7'b0111111 on both digits, and the BCD result is discarded.
  - LZ_BLANK=1 and tens = 0: tens digit shows 7'b1111111.
  - A write during CONV or LOAD restarts CONV with the new value. The in-flight result is dropped and the display keeps its old pattern.
- Digit encoding, 0–9, active-low: 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit).

## Timing

- Reset, all synchronous:
  - Sync FFs, debounced bits, counters, change flags and output registers go to 0.
  - FSMs go to IDLE.
  - hex_out shows "00" per port (tens blank if LZ_BLANK=1).
  - Reset mid-conversion aborts it.
- io_rdata: combinational. A write to port j is visible on read the cycle after the write edge.
- Display latency: a write accepted at edge k updates hex_out at edge k+8. Edges k+1..k+7 are CONV, edge k+8 is LOAD.
- Input latency:
  - A raw switch change held stable reaches the debounced bit at edge DEBOUNCE_CYCLES+2 after its first sampled edge (2 sync, DEBOUNCE_CYCLES count).
  - The flag sets on the same edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced bit.
- All output ports convert independently and concurrently.

## Test plan

- Reset → hex_out per port = {7'h40,7'h40}. Reading 0x00, 0x40 and 0x7C returns 0.
- Write 42 to 0x44 at edge k → hex_out[27:14] = {7'h19,7'h24} exactly at edge k+8, unchanged before. Read 0x44 = 42.
- Write 150 to 0x40 → port 0 shows dashes {7'h3F,7'h3F} at k+8. Read 0x40 = 150.
- Write 7 then 63 to 0x48 three cycles apart → "07" never appears; "63" ({7'h02,7'h30}) appears 8 edges after the second write. With LZ_BLANK=1, writing 7 alone shows {7'h7F,7'h78}.
- Input port 0 bit 0 (DEBOUNCE_CYCLES=16):
  - Pulse high for 10 cycles → no change.
  - Hold high → read 0x00 = 1 at edge 18; status = 1.
  - Write 1 to 0x7C → status = 0.
- W1C coincident with a new debounced change → flag stays 1. Reset asserted during CONV → "00" and IDLE next cycle.

Source files
------------

// File: rtl/io_port_bank_if.sv
// CPU-side data-memory I/O bus for io_port_bank: word-aligned byte address, write strobe,
// write data and combinational read data.

interface io_port_bank_if;
    logic [7:0]  io_addr;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_addr,
        output io_we,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_addr,
        input  io_we,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: debounced switch input ports with sticky change flags, and output
// registers each driving a two-digit active-low 7-segment pair via sequential double-dabble.

module io_port_bank #(
    parameter int unsigned NUM_IN          = 2,
    parameter int unsigned SW_PER_IN       = 5,
    parameter int unsigned NUM_OUT         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          LZ_BLANK        = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    io_port_bank_if.slave               bus,
    input  logic [NUM_IN*SW_PER_IN-1:0] sw,
    output logic [14*NUM_OUT-1:0]       hex_out
);

    localparam int unsigned NumSw = NUM_IN * SW_PER_IN;
    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0]  SegDash  = 7'h3F;
    localparam logic [6:0]  SegBlank = 7'h7F;
    localparam logic [6:0]  SegZero  = 7'h40;
    localparam logic [13:0] HexReset = {(LZ_BLANK ? SegBlank : SegZero), SegZero};

    localparam logic [5:0] StatusWord = 6'd31;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } conv_state_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // One double-dabble step on {tens, ones, binary[6:0]}: add-3 correction, then shift left.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] a;
        a = v;
        if (a[10:7] >= 4'd5) a[10:7] = a[10:7] + 4'd3;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        return {a[13:0], 1'b0};
    endfunction

    logic [5:0] word;
    assign word = bus.io_addr[7:2];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.io_addr[1:0];

    // ---------------------------------------------------------------- input path
    logic [NumSw-1:0] sync1_q, sync2_q, deb_q, deb_d;
    logic [CntW-1:0]  cnt_q [NumSw];
    logic [CntW-1:0]  cnt_d [NumSw];

    always_comb begin
        deb_d = deb_q;
        for (int s = 0; s < NumSw; s++) begin
            cnt_d[s] = '0;
            if (sync2_q[s] != deb_q[s]) begin
                if (cnt_q[s] == CntMax) begin
                    deb_d[s] = sync2_q[s];
                end else begin
                    cnt_d[s] = cnt_q[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int s = 0; s < NumSw; s++) cnt_q[s] <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int s = 0; s < NumSw; s++) cnt_q[s] <= cnt_d[s];
        end
    end

    // ---------------------------------------------------------------- change flags
    logic [NUM_IN-1:0] flag_q, flag_set, flag_clr;
    logic              status_we;

    assign status_we = bus.io_we && (word == StatusWord);

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            flag_set[i] = |(deb_d[i*SW_PER_IN +: SW_PER_IN] ^ deb_q[i*SW_PER_IN +: SW_PER_IN]);
        end
        flag_clr = status_we ? bus.io_wdata[NUM_IN-1:0] : '0;
    end

    // A set on the same edge as a W1C wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= '0;
        end else begin
            flag_q <= (flag_q & ~flag_clr) | flag_set;
        end
    end

    // ---------------------------------------------------------------- output ports
    logic [NUM_OUT-1:0]    out_we;
    logic [32*NUM_OUT-1:0] out_flat;

    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            out_we[j] = bus.io_we && (word == 6'(16 + j));
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        conv_state_e state_q;
        logic [31:0] out_q;
        logic [2:0]  step_q;
        logic [14:0] dd_q;
        logic [13:0] hex_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StIdle;
                out_q   <= '0;
                step_q  <= '0;
                dd_q    <= '0;
                hex_q   <= HexReset;
            end else if (out_we[j]) begin
                // A new write always restarts conversion; any in-flight result is dropped.
                out_q   <= bus.io_wdata;
                dd_q    <= {8'h00, bus.io_wdata[6:0]};
                step_q  <= '0;
                state_q <= StConv;
            end else begin
                unique case (state_q)
                    StConv: begin
                        dd_q   <= dd_step(dd_q);
                        step_q <= step_q + 3'd1;
                        if (step_q == 3'd6) state_q <= StLoad;
                    end
                    StLoad: begin
                        if (out_q > 32'd99) begin
                            hex_q <= {SegDash, SegDash};
                        end else begin
                            hex_q <= {((LZ_BLANK && dd_q[14:11] == 4'd0) ? SegBlank
                                                                           : seg7(dd_q[14:11])),
                                      seg7(dd_q[10:7])};
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign out_flat[32*j +: 32] = out_q;
        assign hex_out[14*j +: 14]  = hex_q;
    end

    // ---------------------------------------------------------------- read mux
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (word == 6'(i)) rdata = 32'(deb_q[i*SW_PER_IN +: SW_PER_IN]);
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (word == 6'(16 + j)) rdata = out_flat[32*j +: 32];
        end
        if (word == StatusWord) rdata = 32'(flag_q);
    end

    assign bus.io_rdata = rdata;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: reset state, display conversion/latency, dashes, restart,
// leading-zero blanking, debounce timing, sticky W1C flags and reset during conversion.

module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw = '0;
    logic [41:0] hex0, hex1;

    int vectors = 0;
    int miscompares = 0;

    logic [13:0] zz = {7'h40, 7'h40};
    logic [13:0] bz = {7'h7F, 7'h40};
    logic [31:0] rd;

    io_port_bank_if bus0 ();
    io_port_bank_if bus1 ();

    io_port_bank #(
        .NUM_IN(2), .SW_PER_IN(5), .NUM_OUT(3), .DEBOUNCE_CYCLES(16), .LZ_BLANK(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .sw(sw), .hex_out(hex0)
    );

    io_port_bank #(
        .NUM_IN(2), .SW_PER_IN(5), .NUM_OUT(3), .DEBOUNCE_CYCLES(16), .LZ_BLANK(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .sw(sw), .hex_out(hex1)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write0(input logic [7:0] a, input logic [31:0] d);
        bus0.io_addr  = a;
        bus0.io_wdata = d;
        bus0.io_we    = 1'b1;
        tick(1);
        bus0.io_we    = 1'b0;
    endtask

    task automatic read0(input logic [7:0] a, output logic [31:0] d);
        bus0.io_addr = a;
        #1;
        d = bus0.io_rdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        vectors++;
        if (hex0 !== {zz, zz, zz}) begin
            miscompares++;
            $display("FAIL reset_hex got %h want %h", hex0, {zz, zz, zz});
        end
        vectors++;
        if (hex1 !== {bz, bz, bz}) begin
            miscompares++;
            $display("FAIL reset_hex_lz got %h want %h", hex1, {bz, bz, bz});
        end
        read0(8'h00, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd00 got %h want 0", rd); end
        read0(8'h40, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd40 got %h want 0", rd); end
        read0(8'h7C, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd7c got %h want 0", rd); end
    endtask

    task automatic test_write_42;
        write0(8'h44, 32'd42);
        read0(8'h44, rd);
        vectors++;
        if (rd !== 32'd42) begin miscompares++; $display("FAIL rd44 got %0d want 42", rd); end
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            vectors++;
            if (n < 8 && hex0[27:14] !== zz) begin
                miscompares++;
                $display("FAIL p1_early edge+%0d got %h want %h", n, hex0[27:14], zz);
            end else if (n == 8 && hex0[27:14] !== {7'h19, 7'h24}) begin
                miscompares++;
                $display("FAIL p1_42 got %h want %h", hex0[27:14], {7'h19, 7'h24});
            end
        end
    endtask

    task automatic test_dashes;
        write0(8'h40, 32'd150);
        tick(7);
        vectors++;
        if (hex0[13:0] !== zz) begin
            miscompares++;
            $display("FAIL p0_early got %h want %h", hex0[13:0], zz);
        end
        tick(1);
        vectors++;
        if (hex0[13:0] !== {7'h3F, 7'h3F}) begin
            miscompares++;
            $display("FAIL p0_dash got %h want %h", hex0[13:0], {7'h3F, 7'h3F});
        end
        read0(8'h40, rd);
        vectors++;
        if (rd !== 32'd150) begin miscompares++; $display("FAIL rd40 got %0d want 150", rd); end
    endtask

    task automatic test_restart_and_blank;
        // dut1 port 0 gets 7 on the same edge as dut0 port 2's first write.
        bus1.io_addr  = 8'h40;
        bus1.io_wdata = 32'd7;
        bus1.io_we    = 1'b1;
        write0(8'h48, 32'd7);
        bus1.io_we    = 1'b0;
        tick(2);
        write0(8'h48, 32'd63);
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            vectors++;
            if (n < 8 && hex0[41:28] !== zz) begin
                miscompares++;
                $display("FAIL p2_restart edge+%0d got %h want %h", n, hex0[41:28], zz);
            end else if (n == 8 && hex0[41:28] !== {7'h02, 7'h30}) begin
                miscompares++;
                $display("FAIL p2_63 got %h want %h", hex0[41:28], {7'h02, 7'h30});
            end
            if (n == 4 || n == 5) begin
                vectors++;
                if (n == 4 && hex1[13:0] !== bz) begin
                    miscompares++;
                    $display("FAIL lz_early got %h want %h", hex1[13:0], bz);
                end else if (n == 5 && hex1[13:0] !== {7'h7F, 7'h78}) begin
                    miscompares++;
                    $display("FAIL lz_07 got %h want %h", hex1[13:0], {7'h7F, 7'h78});
                end
            end
        end
    endtask

    task automatic test_unmapped;
        write0(8'h4C, 32'd99);
        read0(8'h4C, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL rd4c got %h want 0", rd); end
        read0(8'h20, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL rd20 got %h want 0", rd); end
        read0(8'h4B, rd);
        vectors++;
        if (rd !== 32'd63) begin miscompares++; $display("FAIL rd4b got %0d want 63", rd); end
    endtask

    task automatic test_debounce;
        sw[0] = 1'b1;
        tick(10);
        sw[0] = 1'b0;
        tick(30);
        read0(8'h00, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL glitch_in got %h want 0", rd); end
        read0(8'h7C, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL glitch_flag got %h want 0", rd); end

        sw[0] = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            tick(1);
            if (n >= 17) begin
                read0(8'h00, rd);
                vectors++;
                if (rd !== 32'(n - 17)) begin
                    miscompares++;
                    $display("FAIL hold_in edge %0d got %h want %h", n, rd, 32'(n - 17));
                end
                read0(8'h7C, rd);
                vectors++;
                if (rd !== 32'(n - 17)) begin
                    miscompares++;
                    $display("FAIL hold_flag edge %0d got %h want %h", n, rd, 32'(n - 17));
                end
            end
        end
        write0(8'h7C, 32'd1);
        read0(8'h7C, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL w1c got %h want 0", rd); end
        read0(8'h00, rd);
        vectors++;
        if (rd !== 32'd1) begin miscompares++; $display("FAIL in_kept got %h want 1", rd); end
    endtask

    task automatic test_w1c_coincident;
        sw[0] = 1'b0;
        tick(17);
        read0(8'h7C, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL pre_coin got %h want 0", rd); end
        write0(8'h7C, 32'd1);
        read0(8'h7C, rd);
        vectors++;
        if (rd !== 32'd1) begin miscompares++; $display("FAIL coin_flag got %h want 1", rd); end
        read0(8'h00, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL coin_in got %h want 0", rd); end
    endtask

    task automatic test_reset_conv;
        write0(8'h44, 32'd55);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++;
        if (hex0 !== {zz, zz, zz}) begin
            miscompares++;
            $display("FAIL rst_conv_hex got %h want %h", hex0, {zz, zz, zz});
        end
        vectors++;
        if (hex1 !== {bz, bz, bz}) begin
            miscompares++;
            $display("FAIL rst_conv_lz got %h want %h", hex1, {bz, bz, bz});
        end
        read0(8'h44, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL rst_rd44 got %h want 0", rd); end
        tick(8);
        vectors++;
        if (hex0 !== {zz, zz, zz}) begin
            miscompares++;
            $display("FAIL rst_idle_hex got %h want %h", hex0, {zz, zz, zz});
        end
    endtask

    initial begin
        bus0.io_addr  = '0;
        bus0.io_we    = 1'b0;
        bus0.io_wdata = '0;
        bus1.io_addr  = '0;
        bus1.io_we    = 1'b0;
        bus1.io_wdata = '0;
        test_reset();
        test_write_42();
        test_dashes();
        test_restart_and_blank();
        test_unmapped();
        test_debounce();
        test_w1c_coincident();
        test_reset_conv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

endmodule
